// File: rtl/ula_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings, FSM states
// and op classification helpers.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Ops that run the slice adder; only these report carry_out and overflow.
  function automatic logic op_is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Ops that invert B and inject a carry-in of 1 at the LSB.
  function automatic logic op_is_sub(alu_op_e op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/ula_shreg.sv
// WIDTH-bit register with parallel load and shift-right, serial input entering
// at the MSB. Load has priority over shift.
module ula_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge value of its neighbours, which is what makes the shift work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= {ser_i, data_q[WIDTH-1:1]};
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ula_serial_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice: streams operands
// LSB first, ripples carry through a register and assembles the result.
module ula_serial_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [2:0]       s_alucontrol,
  output logic             s_srca,
  output logic             s_srcb,
  output logic             s_cin,
  output logic             s_addsub,
  output logic             s_less,
  input  logic             s_set,
  input  logic             s_result,
  input  logic             s_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  alu_op_e          op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] result_d;
  logic             accept;
  logic             running;
  logic             last_bit;
  logic             arith;
  logic             msb_ovf;
  logic             unused_bits;

  assign accept   = (state_q == ST_IDLE) && start;
  assign running  = (state_q == ST_RUN);
  assign last_bit = running && (cnt_q == CNT_LAST);
  assign arith    = op_is_arith(op_q);

  ula_shreg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .reset(reset), .load_i(accept), .shift_i(running),
    .load_val_i(src_a), .ser_i(1'b0), .q_o(a_sh)
  );

  ula_shreg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .reset(reset), .load_i(accept), .shift_i(running),
    .load_val_i(src_b), .ser_i(1'b0), .q_o(b_sh)
  );

  ula_shreg #(.WIDTH(WIDTH)) u_res_sh (
    .clk(clk), .reset(reset), .load_i(accept), .shift_i(running),
    .load_val_i('0), .ser_i(s_result), .q_o(res_sh)
  );

  // Only the LSB of the operand shifters and the upper bits of res_sh are consumed.
  assign unused_bits = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1], res_sh[0]};

  assign s_alucontrol = op_q;
  assign s_addsub     = op_is_sub(op_q);
  assign s_less       = 1'b0;
  assign s_srca       = running & a_sh[0];
  assign s_srcb       = running & b_sh[0];
  assign s_cin        = running & ((cnt_q == '0) ? s_addsub : carry_q);

  assign msb_ovf  = s_cin ^ s_cout;
  assign res_full = {s_result, res_sh[WIDTH-1:1]};

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    result_d = res_full;
    if (op_q == OP_SLT) begin
      result_d = {{(WIDTH-1){1'b0}}, s_set ^ msb_ovf};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= alu_op_e'(alu_control);
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry_q <= s_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            // The MSB slice outputs are still live here, so result and flags
            // are resolved on the same edge that enters DONE.
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= result_d;
            zero_q      <= (result_d == '0);
            carry_out_q <= arith & s_cout;
            overflow_q  <= arith & msb_ovf;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ula_serial_seq.sv
// Bench for ula_serial_seq with a behavioural 1-bit slice as responder; fixed
// vectors, multi-cycle corner sequences and random ops against a word-level model.
module tb_ula_serial_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, zero, carry_out, overflow;
  logic [W-1:0] result;
  logic [2:0]   s_alucontrol;
  logic         s_srca, s_srcb, s_cin, s_addsub, s_less;
  logic         s_set, s_result, s_cout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ula_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result),
    .zero(zero), .carry_out(carry_out), .overflow(overflow),
    .s_alucontrol(s_alucontrol), .s_srca(s_srca), .s_srcb(s_srcb),
    .s_cin(s_cin), .s_addsub(s_addsub), .s_less(s_less),
    .s_set(s_set), .s_result(s_result), .s_cout(s_cout)
  );

  // 1-bit ALU slice responder (full adder with optional B inversion).
  logic bb, sum;
  always_comb begin
    bb       = s_addsub ? ~s_srcb : s_srcb;
    sum      = s_srca ^ bb ^ s_cin;
    s_cout   = (s_srca & bb) | (s_cin & (s_srca ^ bb));
    s_set    = sum;
    s_result = 1'b0;
    case (s_alucontrol)
      3'b000: s_result = s_srca & s_srcb;
      3'b001: s_result = s_srca | s_srcb;
      3'b010: s_result = sum;
      3'b011: s_result = ~(s_srca | s_srcb);
      3'b100: s_result = s_srca ^ s_srcb;
      3'b101: s_result = ~(s_srca & s_srcb);
      3'b110: s_result = sum;
      default: s_result = s_less;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, v;
  } ref_t;

  // Word-level reference computed directly from the op definitions.
  function automatic ref_t ref_model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    ref_t   r;
    logic [W:0] s;
    r.c = 1'b0;
    r.v = 1'b0;
    case (op)
      3'b000: r.res = a & b;
      3'b001: r.res = a | b;
      3'b011: r.res = ~(a | b);
      3'b100: r.res = a ^ b;
      3'b101: r.res = ~(a & b);
      3'b010: begin
        s     = {1'b0, a} + {1'b0, b};
        r.res = s[W-1:0];
        r.c   = s[W];
        r.v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      default: begin
        s     = {1'b0, a} + {1'b0, ~b} + 1;
        r.c   = s[W];
        r.v   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        r.res = (op == 3'b111) ? W'($signed(a) < $signed(b)) : s[W-1:0];
      end
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Runs one op; returns outputs sampled in the done cycle, latency counted in
  // cycles from the accepting edge, busy cycle count and whether done stayed one cycle.
  // pulse_at > 0 injects a foreign start request during RUN.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, output ref_t got, output int lat,
                        output int busy_cyc, output logic done_after);
    @(negedge clk);
    start = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 100) begin
      busy_cyc += int'(busy);
      if (pulse_at > 0 && lat == pulse_at) begin
        start = 1'b1; alu_control = ~op; src_a = $urandom; src_b = $urandom;
      end else if (pulse_at > 0 && lat == pulse_at + 2) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    got.res = result; got.z = zero; got.c = carry_out; got.v = overflow;
    @(negedge clk);
    done_after = done | busy;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         z, c, v;
  } vec_t;

  vec_t vecs[12];

  task automatic check_op(input string tag, input ref_t got, input ref_t exp, input int lat,
                          input int busy_cyc, input logic done_after);
    check({tag, "_res"}, got.res, exp.res);
    check({tag, "_zero"}, W'(got.z), W'(exp.z));
    check({tag, "_cout"}, W'(got.c), W'(exp.c));
    check({tag, "_ovf"}, W'(got.v), W'(exp.v));
    check({tag, "_latency"}, W'(lat), W'(W + 1));
    check({tag, "_busy_cycles"}, W'(busy_cyc), W'(W));
    check({tag, "_done_one_cycle"}, W'(done_after), '0);
  endtask

  initial begin
    ref_t got, exp;
    int   lat, bc, t_first, t_second, ndone;
    logic da;

    vecs[0]  = '{3'b010, 32'd5,        32'd3,        32'd8,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b110, 32'd7,        32'd7,        32'd0,        1'b1, 1'b1, 1'b0};
    vecs[3]  = '{3'b111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b1};
    vecs[5]  = '{3'b011, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; alu_control = 3'b000; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", W'({busy, done, zero, carry_out, overflow}), '0);
    check("reset_result", result, '0);
    check("reset_slice_bits", W'({s_srca, s_srcb, s_cin, s_less}), '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_flags", W'({busy, done}), '0);

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, got, lat, bc, da);
      exp = '{vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v};
      check_op($sformatf("vec%0d", i), got, exp, lat, bc, da);
    end

    // start pulsed mid-RUN with different operands must be ignored
    run_op(3'b010, 32'd100, 32'd23, 5, got, lat, bc, da);
    check_op("midrun_start", got, ref_model(3'b010, 32'd100, 32'd23), lat, bc, da);

    // start held high: back-to-back ops every W+2 cycles
    @(negedge clk);
    start = 1'b1; alu_control = 3'b010; src_a = 32'd2; src_b = 32'd3;
    t_first = 0; t_second = 0; ndone = 0;
    for (int t = 1; t < 200 && ndone < 2; t++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check($sformatf("b2b_res%0d", ndone), result, 32'd5);
        if (ndone == 1) t_first = t;
        else begin
          t_second = t;
          start = 1'b0;
        end
      end
    end
    check("b2b_first_latency", W'(t_first), W'(W + 1));
    check("b2b_spacing", W'(t_second - t_first), W'(W + 2));
    repeat (3) @(negedge clk);
    check("b2b_no_extra_op", W'({busy, done}), '0);

    // Reset mid-operation: leave nonzero flags from a prior op, then abort at cnt=10
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, got, lat, bc, da);
    check("pre_abort_res", got.res, 32'hFFFFFFFE);
    check("pre_abort_cout", W'(got.c), W'(1'b1));
    @(negedge clk);
    start = 1'b1; alu_control = 3'b010; src_a = 32'h12345678; src_b = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_flags", W'({busy, done, zero, carry_out, overflow}), '0);
    check("abort_result", result, '0);
    check("abort_slice_bits", W'({s_srca, s_srcb, s_cin}), '0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'b010, 32'd1, 32'd1, 0, got, lat, bc, da);
    check_op("after_abort", got, ref_model(3'b010, 32'd1, 32'd1), lat, bc, da);

    // Random ops against the word-level model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = 32'h80000000;
        2: b = a;
        3: a = '1;
        default: ;
      endcase
      run_op(op, a, b, 0, got, lat, bc, da);
      exp = ref_model(op, a, b);
      check($sformatf("rnd%0d_op%0d_res", i, op), got.res, exp.res);
      check($sformatf("rnd%0d_op%0d_flags", i, op), W'({got.z, got.c, got.v}),
            W'({exp.z, exp.c, exp.v}));
      check($sformatf("rnd%0d_latency", i), W'(lat), W'(W + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
